// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: drain FSM states and default FIFO depth.
package uart_pkg;

    localparam int UART_FIFO_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        STROBE      = 2'd1,
        WAIT_ACCEPT = 2'd2,
        WAIT_DONE   = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with registered occupancy flags and a sticky overflow flag.
// Read data is the byte at rd_ptr, presented combinationally for the drain FSM to capture.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [7:0]            data_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [7:0]            rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o
);

    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = (ADDR_WIDTH)'(1);

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_n;
    logic                  push_ok;
    logic                  pop_ok;

    // A push while full is dropped even if a pop lands on the same edge.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        count_n = count;
        if (push_ok && !pop_ok) begin
            count_n = count + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_n = count - CNT_ONE;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full_o     <= 1'b0;
            empty_o    <= 1'b1;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count   <= count_n;
            full_o  <= (count_n == DEPTH_CNT);
            empty_o <= (count_n == '0);
            if (push_i && full_o) begin
                overflow_o <= 1'b1;
            end
        end
    end

    assign count_o   = count;
    assign rd_data_o = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO that drains bytes into a UART transmitter one at a time.
// Transmitter handshake: tx_write_o low offers tx_data_o; it stays low until tx_busy_i=1 is
// seen (accept), and the next byte is offered only after tx_busy_i has returned to 0.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [7:0]            data_i,
    input  logic                  push_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_write_o,
    input  logic                  tx_busy_i,
    output tx_state_e             state_o
);

    tx_state_e  state;
    tx_state_e  state_n;
    logic       pop;
    logic       write_n;
    logic [7:0] rd_data;

    uart_byte_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .data_i     (data_i),
        .push_i     (push_i),
        .pop_i      (pop),
        .rd_data_o  (rd_data),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_o && !tx_busy_i) begin
                    pop     = 1'b1;
                    state_n = STROBE;
                end
            end
            STROBE:      state_n = WAIT_ACCEPT;
            WAIT_ACCEPT: if (tx_busy_i) state_n = WAIT_DONE;
            WAIT_DONE:   if (!tx_busy_i) state_n = IDLE;
            default:     state_n = IDLE;
        endcase
        // Strobe is registered, so it follows the state being entered on this edge.
        write_n = !((state_n == STROBE) || (state_n == WAIT_ACCEPT));
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state      <= IDLE;
            tx_write_o <= 1'b1;
            tx_data_o  <= 8'h00;
        end else begin
            state      <= state_n;
            tx_write_o <= write_n;
            if (pop) begin
                tx_data_o <= rd_data;
            end
        end
    end

    assign state_o = state;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, which sets FIFO depth to 2**ADDR_WIDTH bytes (16 by default).
REQ-002 The block SHALL have port clock_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset_i, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have port data_i, input, 8 bits: byte to enqueue.
REQ-005 The block SHALL have port push_i, input, 1 bit: active-high enqueue request, one byte per cycle.
REQ-006 The block SHALL have port full_o, output, 1 bit: FIFO holds 2**ADDR_WIDTH bytes.
REQ-007 The block SHALL have port empty_o, output, 1 bit: FIFO holds 0 bytes.
REQ-008 The block SHALL have port count_o, output, ADDR_WIDTH+1 bits: current occupancy.
REQ-009 The block SHALL have port overflow_o, output, 1 bit: sticky flag, set on push while full.
REQ-010 The block SHALL have port tx_data_o, output, 8 bits: byte to the transmitter data input.
REQ-011 The block SHALL have port tx_write_o, output, 1 bit: active-low write strobe to the transmitter write input.
REQ-012 The block SHALL have port tx_busy_i, input, 1 bit: transmitter busy, active-high.

Function
REQ-013 A push SHALL be accepted iff push_i=1 and full_o=0 at that clock edge; the byte is written at wr_ptr, wr_ptr increments modulo depth, and count increments.
REQ-014 A push with full_o=1 SHALL be dropped, leave the FIFO unchanged, and set overflow_o=1 until reset.
REQ-015 full_o, empty_o and count_o SHALL be registered and SHALL reflect the FIFO state after the current edge, so they are valid the cycle after a push or pop.
REQ-016 A simultaneous accepted push and pop SHALL leave count unchanged, and both pointers SHALL advance.
REQ-017 The drain FSM SHALL have states IDLE, STROBE, WAIT_ACCEPT and WAIT_DONE.
REQ-018 In IDLE with empty_o=0 and tx_busy_i=0, the FSM SHALL pop one byte into tx_data_o, drive tx_write_o=0, and go to STROBE on the same edge.
REQ-019 In STROBE, the FSM SHALL hold tx_write_o=0 and go to WAIT_ACCEPT.
REQ-020 In WAIT_ACCEPT, tx_write_o SHALL stay 0 until tx_busy_i=1 is sampled; tx_write_o then goes to 1 and the FSM goes to WAIT_DONE.
REQ-021 In WAIT_DONE, the FSM SHALL wait for tx_busy_i=0 and then go to IDLE; a new pop is not allowed before the next IDLE evaluation.
REQ-022 tx_data_o SHALL be stable from the pop edge until the next pop.
REQ-023 tx_write_o SHALL be 1 in IDLE and WAIT_DONE.
REQ-024 Bytes SHALL leave the FIFO in push order, with pointer wrap-around modulo depth.
REQ-025 Minimum latency SHALL be 2 cycles: a push into an empty FIFO with idle transmitter gives tx_write_o=0 two edges later (one edge to store, one edge to pop).
REQ-026 Pointer and count arithmetic SHALL be unsigned; count SHALL never exceed 2**ADDR_WIDTH or go below 0.

Reset
REQ-027 When reset_i=0 is sampled, the block SHALL clear wr_ptr, rd_ptr and count, set the FSM to IDLE, and drive tx_write_o=1, tx_data_o=8'h00, overflow_o=0, empty_o=1 and full_o=0.
REQ-028 Reset SHALL take priority over push and pop in the same cycle.
REQ-029 Reset during STROBE, WAIT_ACCEPT or WAIT_DONE SHALL release tx_write_o to 1 at that edge and discard the in-flight byte.
REQ-030 Storage contents SHALL NOT need reset.

Structure
REQ-031 A shared package uart_pkg SHALL hold the FSM state enumeration and the default depth constant UART_FIFO_ADDR_WIDTH=4.
REQ-032 One sub-module, uart_byte_fifo, SHALL hold the storage, pointers, count, flags and overflow logic.
REQ-033 uart_tx_fifo SHALL contain the drain FSM and instantiate uart_byte_fifo.
REQ-034 Storage SHALL be inferable as a simple dual-port RAM or register array with synchronous write.

Verification
REQ-035 Scenario: reset, then push 8'hA5 with tx_busy_i=0 -> tx_write_o=0 two cycles after the push edge, tx_data_o=8'hA5.
REQ-036 Scenario: a busy model raises tx_busy_i 1 cycle after the strobe and holds it 50 cycles -> tx_write_o returns to 1 after busy rises, and no second strobe occurs before busy falls.
REQ-037 Scenario: hold tx_busy_i=1 and push 17 bytes 0x00..0x10 -> full_o=1 after 16 pushes, overflow_o=1, count_o=16, and the drained sequence is 0x00..0x0F.
REQ-038 Scenario: push and pop in the same cycle at count=5 -> count_o stays 5, and order is preserved across pointer wrap after 40 bytes.
REQ-039 Scenario: reset_i=0 during WAIT_ACCEPT -> next cycle tx_write_o=1, empty_o=1, count_o=0, overflow_o=0.
REQ-040 Scenario: transmitter never raises busy -> tx_write_o stays 0 in WAIT_ACCEPT and no further pops occur.
